// File: rtl/turn_sequencer.sv
// turn_sequencer: game-move controller for a two-player board game.
// Alternates turns between the triangle and circle players and takes one
// (x,y) submission per turn. It range-checks the coordinate, reads the board
// cell and writes the mover's mark only if the cell is empty. When both
// players have placed MOVES_PER_PLAYER pieces it declares game over.
//
// Ports:
//   clk, reset          system clock, synchronous active-high reset
//   x_in, y_in          coordinate from the input handler
//   coord_valid         level; a rising edge submits a move
//   mem_addr            board cell address (y*BOARD_SIZE + x)
//   mem_rd_en           board read strobe; mem_rd_data valid one cycle later
//   mem_rd_data         cell content, 00 = empty
//   mem_wr_en           board write strobe
//   mem_wr_data         mark to write: 01 = triangle, 10 = circle
//   turn                0 = triangle to move, 1 = circle to move
//   move_accepted       one-cycle pulse on a successful placement
//   move_rejected       one-cycle pulse on a refused move
//   reject_code         01 = out of range, 10 = occupied (00 when not rejecting)
//   tri_count           triangles placed
//   cir_count           circles placed
//   busy                move in progress
//   game_over           all pieces placed
module turn_sequencer #(
  parameter int unsigned BOARD_SIZE       = 10,
  parameter int unsigned ADDR_W           = 7,
  parameter int unsigned MOVES_PER_PLAYER = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        x_in,
  input  logic [3:0]        y_in,
  input  logic              coord_valid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  input  logic [1:0]        mem_rd_data,
  output logic              mem_wr_en,
  output logic [1:0]        mem_wr_data,
  output logic              turn,
  output logic              move_accepted,
  output logic              move_rejected,
  output logic [1:0]        reject_code,
  output logic [3:0]        tri_count,
  output logic [3:0]        cir_count,
  output logic              busy,
  output logic              game_over
);

  localparam int unsigned CNT_W = 4;

  typedef enum logic [2:0] {
    S_WAIT,
    S_READ,
    S_CHECK,
    S_WRITE,
    S_REJECT,
    S_DONE
  } state_t;

  state_t            state, state_next;
  logic              coord_valid_d;
  logic              submit;
  logic [1:0]        code_next;
  logic [ADDR_W-1:0] addr_next;
  logic              turn_next;
  logic [CNT_W-1:0]  tri_next, cir_next;

  assign submit = coord_valid & ~coord_valid_d;

  // Next-state, move bookkeeping and reject classification
  always_comb begin
    state_next = state;
    code_next  = 2'b00;
    addr_next  = mem_addr;
    turn_next  = turn;
    tri_next   = tri_count;
    cir_next   = cir_count;
    case (state)
      S_WAIT: begin
        if (submit) begin
          if (32'(x_in) >= BOARD_SIZE || 32'(y_in) >= BOARD_SIZE) begin
            state_next = S_REJECT;
            code_next  = 2'b01;
          end else begin
            state_next = S_READ;
            addr_next  = ADDR_W'(y_in) * ADDR_W'(BOARD_SIZE) + ADDR_W'(x_in);
          end
        end
      end
      S_READ: state_next = S_CHECK;
      S_CHECK: begin
        if (mem_rd_data != 2'b00) begin
          state_next = S_REJECT;
          code_next  = 2'b10;
        end else begin
          state_next = S_WRITE;
        end
      end
      S_WRITE: begin
        turn_next = ~turn;
        if (turn) cir_next = cir_count + CNT_W'(1);
        else      tri_next = tri_count + CNT_W'(1);
        if (tri_next == CNT_W'(MOVES_PER_PLAYER) && cir_next == CNT_W'(MOVES_PER_PLAYER))
          state_next = S_DONE;
        else
          state_next = S_WAIT;
      end
      S_REJECT: state_next = S_WAIT;
      S_DONE:   state_next = S_DONE;
      default:  state_next = S_WAIT;
    endcase
  end

  // State, counters and outputs; outputs are registered from the next state
  // so each one is high exactly while the FSM sits in the matching state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_WAIT;
      coord_valid_d <= 1'b0;
      turn          <= 1'b0;
      tri_count     <= '0;
      cir_count     <= '0;
      mem_addr      <= '0;
      mem_rd_en     <= 1'b0;
      mem_wr_en     <= 1'b0;
      mem_wr_data   <= 2'b00;
      move_accepted <= 1'b0;
      move_rejected <= 1'b0;
      reject_code   <= 2'b00;
      busy          <= 1'b0;
      game_over     <= 1'b0;
    end else begin
      state         <= state_next;
      coord_valid_d <= coord_valid;
      turn          <= turn_next;
      tri_count     <= tri_next;
      cir_count     <= cir_next;
      mem_addr      <= addr_next;
      mem_rd_en     <= (state_next == S_READ);
      mem_wr_en     <= (state_next == S_WRITE);
      mem_wr_data   <= (state_next == S_WRITE) ? (turn ? 2'b10 : 2'b01) : 2'b00;
      move_accepted <= (state_next == S_WRITE);
      move_rejected <= (state_next == S_REJECT);
      reject_code   <= code_next;
      busy          <= (state_next != S_WAIT) && (state_next != S_DONE);
      game_over     <= (state_next == S_DONE);
    end
  end

endmodule

// File: tb/tb_turn_sequencer.sv
// Directed bench for turn_sequencer with a board-memory model and an
// event scoreboard: every submission pushes its expected strobe cycles,
// and a negedge monitor pops and compares each observed strobe cycle.
module tb_turn_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] x_in, y_in;
  logic       coord_valid;
  logic [6:0] mem_addr;
  logic       mem_rd_en;
  logic [1:0] mem_rd_data;
  logic       mem_wr_en;
  logic [1:0] mem_wr_data;
  logic       turn, move_accepted, move_rejected;
  logic [1:0] reject_code;
  logic [3:0] tri_count, cir_count;
  logic       busy, game_over;

  turn_sequencer #(.BOARD_SIZE(10), .ADDR_W(7), .MOVES_PER_PLAYER(8)) dut (
    .clk(clk), .reset(reset), .x_in(x_in), .y_in(y_in),
    .coord_valid(coord_valid), .mem_addr(mem_addr), .mem_rd_en(mem_rd_en),
    .mem_rd_data(mem_rd_data), .mem_wr_en(mem_wr_en),
    .mem_wr_data(mem_wr_data), .turn(turn), .move_accepted(move_accepted),
    .move_rejected(move_rejected), .reject_code(reject_code),
    .tri_count(tri_count), .cir_count(cir_count), .busy(busy),
    .game_over(game_over)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] cyc;
    logic        rd;
    logic        wr;
    logic        acc;
    logic        rej;
    logic [6:0]  addr;
    logic [1:0]  data;
    logic [1:0]  code;
  } ev_t;

  int   cyc = 0;
  int   passes = 0;
  int   fails = 0;
  ev_t  exp_q[$];

  // Board memory model: one-cycle read latency
  logic [1:0] mem [0:127];
  always @(posedge clk) begin
    if (mem_wr_en) mem[mem_addr] <= mem_wr_data;
    mem_rd_data <= mem_rd_en ? mem[mem_addr] : 2'b00;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Expected game state
  bit   exp_board [0:127];
  logic exp_turn;
  int   exp_tri, exp_cir;
  bit   exp_done;

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", name, obs, exp, cyc);
    end
  endtask

  function automatic ev_t mk(int c, logic rd, logic wr, logic acc, logic rej,
                             logic [6:0] addr, logic [1:0] data, logic [1:0] code);
    ev_t e;
    e.cyc = 32'(c); e.rd = rd; e.wr = wr; e.acc = acc; e.rej = rej;
    e.addr = addr; e.data = data; e.code = code;
    return e;
  endfunction

  // Monitor: every cycle carrying a strobe must match the next expected event
  always @(negedge clk) begin
    ev_t o;
    if (mem_rd_en | mem_wr_en | move_accepted | move_rejected) begin
      o = mk(cyc, mem_rd_en, mem_wr_en, move_accepted, move_rejected,
             (mem_rd_en | mem_wr_en) ? mem_addr : 7'd0,
             mem_wr_en ? mem_wr_data : 2'b00, reject_code);
      if (exp_q.size() == 0) check("unexpected_event", 64'(o), 64'(0));
      else check("event", 64'(o), 64'(exp_q.pop_front()));
    end
  end

  // Push the expected events for a submission seen in the current cycle
  task automatic predict(input int x, input int y);
    int t, a;
    t = cyc;
    if (exp_done) return;
    if (x >= 10 || y >= 10) begin
      exp_q.push_back(mk(t + 1, 0, 0, 0, 1, 7'd0, 2'b00, 2'b01));
      return;
    end
    a = y * 10 + x;
    exp_q.push_back(mk(t + 1, 1, 0, 0, 0, 7'(a), 2'b00, 2'b00));
    if (exp_board[a]) begin
      exp_q.push_back(mk(t + 3, 0, 0, 0, 1, 7'd0, 2'b00, 2'b10));
    end else begin
      exp_q.push_back(mk(t + 3, 0, 1, 1, 0, 7'(a), exp_turn ? 2'b10 : 2'b01, 2'b00));
      exp_board[a] = 1'b1;
      if (exp_turn) exp_cir++; else exp_tri++;
      exp_turn = ~exp_turn;
      if (exp_tri == 8 && exp_cir == 8) exp_done = 1'b1;
    end
  endtask

  // Called just after a negedge; returns at the negedge of T+4
  task automatic submit(input int x, input int y);
    x_in = 4'(x); y_in = 4'(y); coord_valid = 1'b1;
    predict(x, y);
    @(negedge clk) coord_valid = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic check_state(input string name);
    check({name, "_turn"}, 64'(turn), 64'(exp_turn));
    check({name, "_tri"}, 64'(tri_count), 64'(exp_tri));
    check({name, "_cir"}, 64'(cir_count), 64'(exp_cir));
    check({name, "_over"}, 64'(game_over), 64'(exp_done));
  endtask

  task automatic check_reset(input string name);
    check(name, 64'({mem_addr, mem_rd_en, mem_wr_en, mem_wr_data, turn,
                     move_accepted, move_rejected, reject_code, tri_count,
                     cir_count, busy, game_over}), 64'(0));
  endtask

  initial begin
    int t;
    for (int i = 0; i < 128; i++) begin
      mem[i] = 2'b00;
      exp_board[i] = 1'b0;
    end
    exp_turn = 1'b0; exp_tri = 0; exp_cir = 0; exp_done = 1'b0;
    reset = 1'b1; coord_valid = 1'b0; x_in = 4'd0; y_in = 4'd0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check_reset("reset_outputs");

    // First triangle move to (3,4) -> address 43
    submit(3, 4);
    check_state("move1");

    // Out of range x
    submit(10, 2);
    check_state("range_reject");

    // Circle targets occupied cell 43, then plays (5,5)
    submit(3, 4);
    check_state("occupied_reject");
    submit(5, 5);
    check_state("move2");

    // Held level with an extra edge while busy: one move only
    t = cyc;
    x_in = 4'd0; y_in = 4'd0; coord_valid = 1'b1;
    predict(0, 0);
    @(negedge clk) coord_valid = 1'b0;
    @(negedge clk) coord_valid = 1'b1;
    repeat (20) @(negedge clk);
    coord_valid = 1'b0;
    repeat (2) @(negedge clk);
    check_state("held_level");
    check("held_busy", 64'(busy), 64'(0));

    // Finish the game with distinct legal cells
    for (int i = 0; i < 13; i++) submit(i % 10, 7 + i / 10);
    check_state("game_end");
    check("end_tri", 64'(tri_count), 64'(8));
    check("end_cir", 64'(cir_count), 64'(8));
    check("end_over", 64'(game_over), 64'(1));

    // Submissions after game over are ignored
    submit(1, 1);
    submit(9, 9);
    check_state("after_done");
    check("after_done_busy", 64'(busy), 64'(0));

    // Reset returns to a fresh game
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    exp_turn = 1'b0; exp_tri = 0; exp_cir = 0; exp_done = 1'b0;
    check_reset("reset_after_done");

    // Reset while in CHECK aborts the move: only the read may appear
    t = cyc;
    x_in = 4'd2; y_in = 4'd2; coord_valid = 1'b1;
    exp_q.push_back(mk(t + 1, 1, 0, 0, 0, 7'd22, 2'b00, 2'b00));
    @(negedge clk) coord_valid = 1'b0;
    @(negedge clk) reset = 1'b1;
    @(negedge clk);
    check_reset("reset_mid_move");
    reset = 1'b0;
    repeat (6) @(negedge clk);
    check_state("after_abort");
    check("abort_mem_clean", 64'(mem[22]), 64'(0));
    check("queue_drained", 64'(exp_q.size()), 64'(0));

    $display("%0d/%0d checks passed", passes, passes + fails);
    $finish;
  end

endmodule

// File: doc/turn_sequencer.md
Name: turn_sequencer

Overview:
Game-move controller placed downstream of the debounced coordinate input handler.
- Alternates turns between the triangle player and the circle player.
- Accepts one (x,y) coordinate per turn and range-checks it.
- Reads the shared board memory to confirm the target cell is empty, then writes the player's mark.
- Counts placed pieces per player and declares game over when both players have placed MOVES_PER_PLAYER pieces.

Parameters:
BOARD_SIZE, 10, board is BOARD_SIZE x BOARD_SIZE; legal coordinates are 0..BOARD_SIZE-1
ADDR_W, 7, board memory address width; must satisfy 2^ADDR_W >= BOARD_SIZE*BOARD_SIZE
MOVES_PER_PLAYER, 8, pieces each player places before game over (1..15)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high
x_in  input  4  x coordinate from input handler
y_in  input  4  y coordinate from input handler
coord_valid  input  1  level from input handler; a rising edge submits a move
mem_addr  output  ADDR_W  board cell address = y*BOARD_SIZE + x
mem_rd_en  output  1  board read strobe
mem_rd_data  input  2  cell content, valid the cycle after mem_rd_en; 00 = empty
mem_wr_en  output  1  board write strobe
mem_wr_data  output  2  01 = triangle, 10 = circle
turn  output  1  0 = triangle to move, 1 = circle to move
move_accepted  output  1  one-cycle pulse
move_rejected  output  1  one-cycle pulse
reject_code  output  2  01 = out of range, 10 = cell occupied; valid with move_rejected, else 00
tri_count  output  4  triangles placed
cir_count  output  4  circles placed
busy  output  1  high in any state other than WAIT and DONE
game_over  output  1  high in DONE

Behaviour:
- Reset:
  - Reset is synchronous, active-high.
  - On reset: state WAIT, turn=0, tri_count=cir_count=0, all strobes and pulses 0, reject_code=00, mem_addr=0, edge register=0.
  - Reset in any state, including mid-read or mid-write, aborts the move with no write issued afterwards.
- Edge detect:
  - Register coord_valid_d every cycle.
  - Submit = coord_valid & ~coord_valid_d.
  - A held-high level never retriggers.
- States are WAIT, READ, CHECK, WRITE, REJECT, DONE.
- WAIT:
  - On submit in cycle T, latch x_in and y_in.
  - If x >= BOARD_SIZE or y >= BOARD_SIZE, go to REJECT with code 01.
  - Otherwise go to READ.
- READ (T+1):
  - mem_rd_en=1 and mem_addr = latched y*BOARD_SIZE + x, computed with ADDR_W-bit arithmetic.
  - Next state is CHECK.
- CHECK (T+2):
  - Sample mem_rd_data.
  - Nonzero: go to REJECT with code 10.
  - Zero: go to WRITE.
- WRITE (T+3):
  - mem_wr_en=1, mem_addr unchanged, mem_wr_data = turn ? 10 : 01, move_accepted=1.
  - At the end of the cycle: increment the mover's count and toggle turn.
  - If the new counts are both MOVES_PER_PLAYER, go to DONE; otherwise go to WAIT.
- REJECT:
  - One cycle with move_rejected=1 and the latched reject_code.
  - turn and the counts are unchanged (the same player moves again).
  - Next state is WAIT.
  - Range reject pulses at T+1; occupied reject pulses at T+3.
- DONE:
  - game_over=1.
  - All submits are ignored; the only exit is reset.
- Submits arriving while busy are ignored and not queued. The edge register keeps updating in every state.
- Outputs are Moore, decoded from state and latched registers.
- Latency from submit edge to accept pulse is 3 cycles; back-to-back moves are possible from T+4.
- Counts never exceed MOVES_PER_PLAYER. Turn strictly alternates, so tri_count - cir_count is always 0 or 1.

Test Plan:
- Reset, then submit (3,4) to empty memory: mem_rd_en at T+1 with addr 43; mem_wr_en, wr_data=01 and move_accepted at T+3; turn=1 and tri_count=1 at T+4.
- Submit (10,2), with BOARD_SIZE=10: move_rejected at T+1 with reject_code=01; no memory strobes; turn unchanged.
- Memory model returns 01 at addr 43, circle submits (3,4): move_rejected at T+3 with code 10; no write; turn stays 1; then (5,5) is accepted with wr_data=10 at addr 55.
- Hold coord_valid high 20 cycles: exactly one move is processed. A second edge at T+1 (pulse low then high) is ignored.
- Play 16 legal distinct moves: after the 16th accept, tri_count=8, cir_count=8, game_over=1; a further submit produces no strobes.
- Assert reset in the cycle the state is CHECK: no mem_wr_en follows; next cycle all outputs are at their reset values.
